// File: rtl/conv_pkg.sv
// Shared types and constants for the Sobel frame sequencer and convolution engine.
package conv_pkg;

  // Coordinate width shared with the convolution engine (covers 1280 x 960).
  localparam int COORD_W = 11;
  localparam int PIX_W   = 12;
  localparam int BEAT_W  = 22;

  localparam logic [1:0] MODE_H   = 2'd0;
  localparam logic [1:0] MODE_V   = 2'd1;
  localparam logic [1:0] MODE_ALT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  // Filter direction for the frame being armed; the reserved mode behaves as horizontal.
  function automatic logic pick_dir(input logic [1:0] mode, input logic dir_next);
    case (mode)
      MODE_V:   pick_dir = 1'b1;
      MODE_ALT: pick_dir = dir_next;
      default:  pick_dir = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pix_xy_counter.sv
// Raster x/y counter: x wraps at WIDTH-1 and carries into y; flags the last pixel of a frame.
module pix_xy_counter
  import conv_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  // Next coordinate: clear wins, otherwise advance one pixel in raster order.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_q == X_MAX) begin
        x_d = '0;
        y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Coordinate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the 3x3 Sobel engine: tags pixels with x/y, drives the
// engine read strobe and direction, and detects drain/completion of each frame.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int WIDTH    = 1280,
  parameter int HEIGHT   = 960,
  parameter int IDLE_GAP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          cfg_mode,
  input  logic                pix_valid,
  input  logic [PIX_W-1:0]    pix_data,
  output logic                pix_ready,
  output logic                conv_read,
  output logic [PIX_W-1:0]    conv_data,
  output logic [COORD_W-1:0]  conv_x,
  output logic [COORD_W-1:0]  conv_y,
  output logic                conv_vertical,
  input  logic                conv_valid,
  output logic                busy,
  output logic                frame_done,
  output logic [BEAT_W-1:0]   out_count,
  output logic                err_overrun
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

  seq_state_e          state_q, state_d;
  logic                dir_q, dir_d, dir_next_q, dir_next_d;
  logic                conv_vertical_q, conv_vertical_d;
  logic                conv_read_q, conv_read_d;
  logic [PIX_W-1:0]    conv_data_q, conv_data_d;
  logic [COORD_W-1:0]  conv_x_q, conv_x_d, conv_y_q, conv_y_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [BEAT_W-1:0]   beat_q, beat_d, out_count_q, out_count_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;

  logic                accept, xy_clr, xy_last;
  logic [COORD_W-1:0]  xy_x, xy_y;

  assign accept = pix_valid && (state_q == S_STREAM);
  assign xy_clr = (state_q == S_ARM);

  pix_xy_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_xy (
    .clk  (clk),
    .rst  (rst),
    .clr  (xy_clr),
    .adv  (accept),
    .x    (xy_x),
    .y    (xy_y),
    .last (xy_last)
  );

  // Next-state, gap timer, beat counter and registered engine-side outputs.
  always_comb begin
    state_d         = state_q;
    dir_d           = dir_q;
    dir_next_d      = dir_next_q;
    conv_vertical_d = conv_vertical_q;
    conv_read_d     = 1'b0;
    conv_data_d     = conv_data_q;
    conv_x_d        = conv_x_q;
    conv_y_d        = conv_y_q;
    gap_d           = gap_q;
    beat_d          = beat_q;
    out_count_d     = out_count_q;
    frame_done_d    = 1'b0;
    // Pixels offered while we cannot take them are lost; flag it (IDLE drops silently).
    err_d = err_q | (pix_valid && (state_q == S_ARM || state_q == S_DRAIN || state_q == S_DONE));
    // Engine output beats, saturating so a runaway engine cannot wrap the count.
    if (conv_valid && (state_q == S_STREAM || state_q == S_DRAIN) && (beat_q != '1))
      beat_d = beat_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d   = pick_dir(cfg_mode, dir_next_q);
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        conv_vertical_d = dir_q;
        beat_d          = '0;
        gap_d           = '0;
        state_d         = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          conv_read_d = 1'b1;
          conv_data_d = pix_data;
          conv_x_d    = xy_x;
          conv_y_d    = xy_y;
          if (xy_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (conv_valid) begin
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        out_count_d = beat_q;
        if (cfg_mode == MODE_ALT) dir_next_d = ~dir_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      dir_q           <= 1'b0;
      dir_next_q      <= 1'b0;
      conv_vertical_q <= 1'b0;
      conv_read_q     <= 1'b0;
      conv_data_q     <= '0;
      conv_x_q        <= '0;
      conv_y_q        <= '0;
      gap_q           <= '0;
      beat_q          <= '0;
      out_count_q     <= '0;
      frame_done_q    <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      dir_next_q      <= dir_next_d;
      conv_vertical_q <= conv_vertical_d;
      conv_read_q     <= conv_read_d;
      conv_data_q     <= conv_data_d;
      conv_x_q        <= conv_x_d;
      conv_y_q        <= conv_y_d;
      gap_q           <= gap_d;
      beat_q          <= beat_d;
      out_count_q     <= out_count_d;
      frame_done_q    <= frame_done_d;
      err_q           <= err_d;
    end
  end

  assign pix_ready     = (state_q == S_STREAM);
  assign busy          = (state_q != S_IDLE);
  assign conv_read     = conv_read_q;
  assign conv_data     = conv_data_q;
  assign conv_x        = conv_x_q;
  assign conv_y        = conv_y_q;
  assign conv_vertical = conv_vertical_q;
  assign frame_done    = frame_done_q;
  assign out_count     = out_count_q;
  assign err_overrun   = err_q;

endmodule
